// File: rtl/mac_pkg.sv
// Shared types and helpers for the gated multiply-accumulate pipeline:
// product width, accumulator saturation limits and the operand mode enum.
package mac_pkg;

    typedef enum logic {
        MAC_UNSIGNED = 1'b0,
        MAC_SIGNED   = 1'b1
    } mac_mode_e;

    // Widest accumulator the saturation helpers can describe.
    localparam int SAT_MAX_W = 256;

    function automatic int prod_w(input int a_w, input int b_w);
        return a_w + b_w;
    endfunction

    // Largest representable accumulator value, right-aligned in SAT_MAX_W bits.
    function automatic logic [SAT_MAX_W-1:0] sat_max(input int acc_w, input int signed_mode);
        logic [SAT_MAX_W-1:0] v;
        v = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - acc_w);
        if (signed_mode != 0) begin
            v = v >> 1;
        end
        return v;
    endfunction

    // Smallest representable accumulator value, right-aligned in SAT_MAX_W bits.
    function automatic logic [SAT_MAX_W-1:0] sat_min(input int acc_w, input int signed_mode);
        logic [SAT_MAX_W-1:0] v;
        v = '0;
        if (signed_mode != 0) begin
            v = SAT_MAX_W'(1) << (acc_w - 1);
        end
        return v;
    endfunction

endpackage

// File: rtl/mac_gated_pipe_clk_gate.sv
// Glitch-free clock gate: the enable is captured by a latch that is transparent
// while clk is low, then ANDed with clk so it can only change while gclk is low.
module clk_gate (
    input  logic clk,
    input  logic en,
    output logic gclk
);

    logic en_lat;

    always_latch begin
        if (!clk) begin
            en_lat = en;
        end
    end

    assign gclk = clk & en_lat;

endmodule

// File: rtl/mac_gated_pipe.sv
// Two-stage multiply-accumulate with a gated clock per stage, term counter and
// sticky overflow. Define MAC_SAT_EN to clamp the accumulator on overflow instead of wrapping.
module mac_gated_pipe
    import mac_pkg::*;
#(
    parameter int A_W    = 8,
    parameter int B_W    = 8,
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 16,
    parameter int SIGNED = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [A_W-1:0]   A,
    input  logic [B_W-1:0]   B,
    output logic [ACC_W-1:0] accum,
    output logic             acc_vld,
    output logic [CNT_W-1:0] term_cnt,
    output logic             ovf
);

    localparam int               P_W     = prod_w(A_W, B_W);
    localparam mac_mode_e        MODE    = (SIGNED != 0) ? MAC_SIGNED : MAC_UNSIGNED;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

`ifdef MAC_SAT_EN
    localparam logic [SAT_MAX_W-1:0] SAT_MAX_FULL = sat_max(ACC_W, SIGNED);
    localparam logic [SAT_MAX_W-1:0] SAT_MIN_FULL = sat_min(ACC_W, SIGNED);
    localparam logic [ACC_W-1:0]     SAT_MAX      = SAT_MAX_FULL[ACC_W-1:0];
    localparam logic [ACC_W-1:0]     SAT_MIN      = SAT_MIN_FULL[ACC_W-1:0];
`endif

    logic             gclk1;
    logic             gclk2;
    logic             gate1_en;
    logic             gate2_en;
    logic [P_W-1:0]   a_ext;
    logic [P_W-1:0]   b_ext;
    logic [P_W-1:0]   prod_next;
    logic [P_W-1:0]   prod_reg;
    logic             vld_s1;
    logic [ACC_W-1:0] prod_ext;
    logic [ACC_W-1:0] sum;
    logic             carry;
    logic             ovf_now;
    logic [ACC_W-1:0] accum_next;

    // rst is in both enables so reset always reaches the gated flops;
    // acc_vld keeps stage 2 clocked for one more edge so the pulse can fall.
    assign gate1_en = en | rst;
    assign gate2_en = vld_s1 | clr | rst | acc_vld;

    clk_gate u_gate1 (.clk(clk), .en(gate1_en), .gclk(gclk1));
    clk_gate u_gate2 (.clk(clk), .en(gate2_en), .gclk(gclk2));

    generate
        if (MODE == MAC_SIGNED) begin : g_signed
            assign a_ext    = P_W'($signed(A));
            assign b_ext    = P_W'($signed(B));
            assign prod_ext = ACC_W'($signed(prod_reg));
        end else begin : g_unsigned
            assign a_ext    = P_W'(A);
            assign b_ext    = P_W'(B);
            assign prod_ext = ACC_W'(prod_reg);
        end
    endgenerate

    // Operands are pre-extended to the full product width, so the low P_W
    // bits of the product are exact for both signed and unsigned operands.
    assign prod_next      = a_ext * b_ext;
    assign {carry, sum}   = {1'b0, accum} + {1'b0, prod_ext};

    always_comb begin
        ovf_now    = carry;
        accum_next = sum;
        if (MODE == MAC_SIGNED) begin
            ovf_now = (accum[ACC_W-1] == prod_ext[ACC_W-1]) && (sum[ACC_W-1] != accum[ACC_W-1]);
        end
`ifdef MAC_SAT_EN
        if (ovf_now) begin
            if (MODE == MAC_SIGNED && accum[ACC_W-1]) begin
                accum_next = SAT_MIN;
            end else begin
                accum_next = SAT_MAX;
            end
        end
`endif
    end

    always_ff @(posedge gclk1) begin
        if (rst) begin
            prod_reg <= '0;
        end else begin
            prod_reg <= prod_next;
        end
    end

    // The stage-1 valid runs on the free clock: gclk1 stops when en drops,
    // and the valid must fall on exactly that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_s1 <= 1'b0;
        end else begin
            vld_s1 <= en;
        end
    end

    always_ff @(posedge gclk2) begin
        if (rst || clr) begin
            accum    <= '0;
            acc_vld  <= 1'b0;
            term_cnt <= '0;
            ovf      <= 1'b0;
        end else if (vld_s1) begin
            accum   <= accum_next;
            acc_vld <= 1'b1;
            if (term_cnt != CNT_MAX) begin
                term_cnt <= term_cnt + CNT_W'(1);
            end
            if (ovf_now) begin
                ovf <= 1'b1;
            end
        end else begin
            acc_vld <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mac_gated_pipe.sv
// Bench for mac_gated_pipe: three instances (unsigned 64-bit, signed 64-bit,
// unsigned 16-bit with a 4-bit counter) share one stimulus stream.
module tb_mac_gated_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        clr;
    logic        en;
    logic [7:0]  a;
    logic [7:0]  b;

    logic [63:0] acc_u, acc_s;
    logic [15:0] acc_o;
    logic        vld_u, vld_s, vld_o;
    logic [15:0] cnt_u, cnt_s;
    logic [3:0]  cnt_o;
    logic        ovf_u, ovf_s, ovf_o;

    always #5 clk = ~clk;

    mac_gated_pipe #(.A_W(8), .B_W(8), .ACC_W(64), .CNT_W(16), .SIGNED(0)) u_u (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .A(a), .B(b),
        .accum(acc_u), .acc_vld(vld_u), .term_cnt(cnt_u), .ovf(ovf_u));

    mac_gated_pipe #(.A_W(8), .B_W(8), .ACC_W(64), .CNT_W(16), .SIGNED(1)) u_s (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .A(a), .B(b),
        .accum(acc_s), .acc_vld(vld_s), .term_cnt(cnt_s), .ovf(ovf_s));

    mac_gated_pipe #(.A_W(8), .B_W(8), .ACC_W(16), .CNT_W(4), .SIGNED(0)) u_o (
        .clk(clk), .rst(rst), .clr(clr), .en(en), .A(a), .B(b),
        .accum(acc_o), .acc_vld(vld_o), .term_cnt(cnt_o), .ovf(ovf_o));

    logic [63:0] d_acc [3];
    logic [15:0] d_cnt [3];
    logic        d_vld [3];
    logic        d_ovf [3];

    always_comb begin
        d_acc[0] = acc_u;
        d_acc[1] = acc_s;
        d_acc[2] = {48'd0, acc_o};
        d_cnt[0] = cnt_u;
        d_cnt[1] = cnt_s;
        d_cnt[2] = {12'd0, cnt_o};
        d_vld[0] = vld_u;
        d_vld[1] = vld_s;
        d_vld[2] = vld_o;
        d_ovf[0] = ovf_u;
        d_ovf[1] = ovf_s;
        d_ovf[2] = ovf_o;
    end

    int g1_edges = 0;
    int g2_edges = 0;
    always @(posedge u_u.gclk1) g1_edges++;
    always @(posedge u_u.gclk2) g2_edges++;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: accumulator kept as a true integer value and checked
    // against the representable range of each instance.
    int                 m_w  [3] = '{64, 64, 16};
    int                 m_cw [3] = '{16, 16, 4};
    bit                 m_s  [3] = '{1'b0, 1'b1, 1'b0};
    logic signed [127:0] m_acc [3];
    logic signed [127:0] m_prod[3];
    bit                 m_pv [3];
    bit                 m_vld[3];
    bit                 m_ovf[3];
    int                 m_cnt[3];

    function automatic logic signed [127:0] span(input int i);
        return 128'sd1 <<< m_w[i];
    endfunction

    task automatic model_edge(input logic r, input logic c, input logic e,
                              input logic [7:0] ai, input logic [7:0] bi);
        for (int i = 0; i < 3; i++) begin
            logic signed [127:0] pw, hi, lo, sum;
            longint pa, pb;
            pw = span(i);
            if (m_s[i]) begin
                hi = (pw >>> 1) - 1;
                lo = -(pw >>> 1);
            end else begin
                hi = pw - 1;
                lo = '0;
            end
            if (r) begin
                m_acc[i] = '0; m_pv[i] = 1'b0; m_vld[i] = 1'b0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
            end else begin
                if (c) begin
                    m_acc[i] = '0; m_vld[i] = 1'b0; m_cnt[i] = 0; m_ovf[i] = 1'b0;
                end else if (m_pv[i]) begin
                    sum = m_acc[i] + m_prod[i];
                    if (sum > hi || sum < lo) begin
                        m_ovf[i] = 1'b1;
`ifdef MAC_SAT_EN
                        m_acc[i] = (sum > hi) ? hi : lo;
`else
                        begin
                            logic signed [127:0] t;
                            t = sum & (pw - 1);
                            if (t > hi) t = t - pw;
                            m_acc[i] = t;
                        end
`endif
                    end else begin
                        m_acc[i] = sum;
                    end
                    m_vld[i] = 1'b1;
                    if (m_cnt[i] < (1 << m_cw[i]) - 1) m_cnt[i]++;
                end else begin
                    m_vld[i] = 1'b0;
                end
                m_pv[i] = e;
                if (e) begin
                    pa = m_s[i] ? longint'($signed(ai)) : longint'(ai);
                    pb = m_s[i] ? longint'($signed(bi)) : longint'(bi);
                    m_prod[i] = 128'(pa * pb);
                end
            end
        end
    endtask

    // Drive inputs (from a falling edge), let one rising edge pass, return on the next falling edge.
    task automatic step(input logic r, input logic c, input logic e,
                        input logic [7:0] ai, input logic [7:0] bi);
        rst = r; clr = c; en = e; a = ai; b = bi;
        @(posedge clk);
        model_edge(r, c, e, ai, bi);
        @(negedge clk);
    endtask

    typedef struct {
        int          sel;
        logic        r, c, e;
        logic [7:0]  a, b;
        logic [63:0] acc;
        logic        vld;
        logic [15:0] cnt;
        logic        ovf;
    } vec_t;

    function automatic vec_t mk(input int sel, input logic r, input logic c, input logic e,
                                input logic [7:0] ai, input logic [7:0] bi, input logic [63:0] acc,
                                input logic vld, input logic [15:0] cnt, input logic ovf);
        vec_t v;
        v.sel = sel; v.r = r; v.c = c; v.e = e; v.a = ai; v.b = bi;
        v.acc = acc; v.vld = vld; v.cnt = cnt; v.ovf = ovf;
        return v;
    endfunction

`ifdef MAC_SAT_EN
    localparam logic [63:0] EXP_OVF16 = 64'hFFFF;
`else
    localparam logic [63:0] EXP_OVF16 = 64'd64514;
`endif

    initial begin
        vec_t tbl[$];
        int   g1_snap, g2_snap;

        rst = 1'b1; clr = 1'b0; en = 1'b0; a = '0; b = '0;

        // Reset state on every instance, then no gated edges while idle.
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("reset acc%0d", i), d_acc[i], 64'd0);
            chk($sformatf("reset vld%0d", i), 64'(d_vld[i]), 64'd0);
            chk($sformatf("reset cnt%0d", i), 64'(d_cnt[i]), 64'd0);
            chk($sformatf("reset ovf%0d", i), 64'(d_ovf[i]), 64'd0);
        end
        g1_snap = g1_edges;
        g2_snap = g2_edges;
        for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0);
        chk("idle gclk1 edges", 64'(g1_edges - g1_snap), 64'd0);
        chk("idle gclk2 edges", 64'(g2_edges - g2_snap), 64'd0);

        // Unsigned back-to-back accumulate and acc_vld pulse train.
        tbl.push_back(mk(0, 0, 0, 1, 8'd3,   8'd4,   64'd0,     0, 16'd0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'd5,   8'd6,   64'd12,    1, 16'd1, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'd255, 8'd255, 64'd42,    1, 16'd2, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'd0,   8'd0,   64'd65067, 1, 16'd3, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'd0,   8'd0,   64'd65067, 0, 16'd3, 0));
        tbl.push_back(mk(0, 0, 1, 0, 8'd0,   8'd0,   64'd0,     0, 16'd0, 0));
        // Signed accumulate.
        tbl.push_back(mk(1, 0, 0, 1, 8'hFD,  8'd4,   64'd0,                  0, 16'd0, 0));
        tbl.push_back(mk(1, 0, 0, 1, 8'd2,   8'hFB,  64'hFFFF_FFFF_FFFF_FFF4, 1, 16'd1, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'd0,   8'd0,   64'hFFFF_FFFF_FFFF_FFEA, 1, 16'd2, 0));
        // clr coinciding with a stage-2 product, while a new product enters stage 1.
        tbl.push_back(mk(1, 0, 0, 1, 8'hFD,  8'd4,   64'hFFFF_FFFF_FFFF_FFEA, 0, 16'd2, 0));
        tbl.push_back(mk(1, 0, 1, 1, 8'd7,   8'd7,   64'd0,                  0, 16'd0, 0));
        tbl.push_back(mk(1, 0, 0, 0, 8'd0,   8'd0,   64'd49,                 1, 16'd1, 0));
        // 16-bit accumulator overflow.
        tbl.push_back(mk(2, 0, 1, 0, 8'd0,   8'd0,   64'd0,     0, 16'd0, 0));
        tbl.push_back(mk(2, 0, 0, 1, 8'd255, 8'd255, 64'd0,     0, 16'd0, 0));
        tbl.push_back(mk(2, 0, 0, 1, 8'd255, 8'd255, 64'd65025, 1, 16'd1, 0));
        tbl.push_back(mk(2, 0, 0, 0, 8'd0,   8'd0,   EXP_OVF16, 1, 16'd2, 1));
        tbl.push_back(mk(2, 0, 0, 0, 8'd0,   8'd0,   EXP_OVF16, 0, 16'd2, 1));
        // rst the edge after en: the in-flight product is lost.
        tbl.push_back(mk(0, 0, 1, 0, 8'd0,   8'd0,   64'd0, 0, 16'd0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8'd9,   8'd9,   64'd0, 0, 16'd0, 0));
        tbl.push_back(mk(0, 1, 0, 0, 8'd0,   8'd0,   64'd0, 0, 16'd0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'd0,   8'd0,   64'd0, 0, 16'd0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 8'd0,   8'd0,   64'd0, 0, 16'd0, 0));

        foreach (tbl[k]) begin
            int s;
            s = tbl[k].sel;
            step(tbl[k].r, tbl[k].c, tbl[k].e, tbl[k].a, tbl[k].b);
            $display("vec %0d sel=%0d rst=%0b clr=%0b en=%0b A=%0h B=%0h -> acc=%0h vld=%0b cnt=%0d ovf=%0b",
                     k, s, tbl[k].r, tbl[k].c, tbl[k].e, tbl[k].a, tbl[k].b,
                     d_acc[s], d_vld[s], d_cnt[s], d_ovf[s]);
            chk($sformatf("vec%0d acc", k), d_acc[s], tbl[k].acc);
            chk($sformatf("vec%0d vld", k), 64'(d_vld[s]), 64'(tbl[k].vld));
            chk($sformatf("vec%0d cnt", k), 64'(d_cnt[s]), 64'(tbl[k].cnt));
            chk($sformatf("vec%0d ovf", k), 64'(d_ovf[s]), 64'(tbl[k].ovf));
        end

        // Term counter saturates at 15 on the 4-bit instance while accumulation continues.
        for (int k = 0; k < 17; k++) step(0, 0, 1, 8'd1, 8'd1);
        step(0, 0, 0, 0, 0);
        $display("sat seq: acc=%0h cnt=%0d ovf=%0b", acc_o, cnt_o, ovf_o);
        chk("cnt sat value", 64'(cnt_o), 64'd15);
        chk("cnt sat acc", 64'(acc_o), 64'd17);
        chk("cnt sat ovf", 64'(ovf_o), 64'd0);

        // Randomised traffic against the reference model.
        step(1, 0, 0, 0, 0);
        for (int k = 0; k < 300; k++) begin
            logic r, c, e;
            logic [7:0] ai, bi;
            r  = ($urandom_range(0, 99) < 1);
            c  = ($urandom_range(0, 99) < 3);
            e  = ($urandom_range(0, 99) < 75);
            ai = 8'($urandom_range(0, 255));
            bi = 8'($urandom_range(0, 255));
            step(r, c, e, ai, bi);
            $display("rnd %0d rst=%0b clr=%0b en=%0b A=%0h B=%0h acc_u=%0h acc_s=%0h acc_o=%0h",
                     k, r, c, e, ai, bi, acc_u, acc_s, acc_o);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rnd%0d acc%0d", k, i), d_acc[i], 64'(m_acc[i] & (span(i) - 1)));
                chk($sformatf("rnd%0d vld%0d", k, i), 64'(d_vld[i]), 64'(m_vld[i]));
                chk($sformatf("rnd%0d cnt%0d", k, i), 64'(d_cnt[i]), 64'(m_cnt[i]));
                chk($sformatf("rnd%0d ovf%0d", k, i), 64'(d_ovf[i]), 64'(m_ovf[i]));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
